// File: rtl/parity_serializer_if.sv
// rtl/parity_serializer_if.sv - valid/ready byte handshake bus feeding the parity serializer
interface parity_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/parity_serializer.sv
// rtl/parity_serializer.sv - byte to LSB-first serial frame with trailing parity bit
// Optional stop bit after the parity bit: define PARITY_STOP_BIT_EN.
module parity_serializer #(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0,
    parameter int IDLE_LEVEL = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parity_serializer_if.slave   bus,
    output logic                 ser_out,
    output logic                 ser_active,
    output logic                 parity_out,
    output logic                 frame_done
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic IDLE_BIT = 1'(IDLE_LEVEL);
    localparam logic ODD_BIT  = 1'(ODD_PARITY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

`ifdef PARITY_STOP_BIT_EN
    localparam state_t LAST_S = S_STOP;
`else
    localparam state_t LAST_S = S_PAR;
`endif

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              accept;

    assign bus.data_ready = (state == S_IDLE) || (state == LAST_S);
    assign accept         = bus.data_valid && bus.data_ready;

    // ser_out is registered one step ahead, so it is loaded with the bit the next state presents
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            ser_out    <= IDLE_BIT;
            ser_active <= 1'b0;
            parity_out <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                state      <= S_DATA;
                shreg      <= bus.data_in;
                cnt        <= '0;
                parity_out <= (^bus.data_in) ^ ODD_BIT;
                ser_out    <= bus.data_in[0];
                ser_active <= 1'b1;
            end else begin
                case (state)
                    S_DATA: begin
                        if (cnt == LAST_CNT) begin
                            state   <= S_PAR;
                            ser_out <= parity_out;
`ifndef PARITY_STOP_BIT_EN
                            frame_done <= 1'b1;
`endif
                        end else begin
                            cnt     <= cnt + CNT_W'(1);
                            shreg   <= shreg >> 1;
                            ser_out <= shreg[1];
                        end
                    end
`ifdef PARITY_STOP_BIT_EN
                    S_PAR: begin
                        state      <= S_STOP;
                        ser_out    <= IDLE_BIT;
                        frame_done <= 1'b1;
                    end
`endif
                    default: begin
                        state      <= S_IDLE;
                        ser_out    <= IDLE_BIT;
                        ser_active <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_parity_serializer.sv
// tb/tb_parity_serializer.sv - scoreboard bench for parity_serializer (even and odd parity instances)
module tb_parity_serializer;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

`ifdef PARITY_STOP_BIT_EN
    localparam int FRAME_LEN = 10;
`else
    localparam int FRAME_LEN = 9;
`endif

    parity_serializer_if #(.DATA_W(8)) bus ();
    parity_serializer_if #(.DATA_W(8)) bus_o ();

    logic ser_out, ser_active, parity_out, frame_done;
    logic so_ser, so_active, so_par, so_done;

    parity_serializer #(.DATA_W(8), .ODD_PARITY(0), .IDLE_LEVEL(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .ser_out(ser_out), .ser_active(ser_active),
        .parity_out(parity_out), .frame_done(frame_done)
    );

    parity_serializer #(.DATA_W(8), .ODD_PARITY(1), .IDLE_LEVEL(1)) dut_o (
        .clk(clk), .rst_n(rst_n), .bus(bus_o.slave),
        .ser_out(so_ser), .ser_active(so_active),
        .parity_out(so_par), .frame_done(so_done)
    );

    typedef struct {
        logic b;
        logic d;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   run = 0;
    int   last_run = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] b, input logic p);
        for (int i = 0; i < 8; i++) q.push_back('{b: b[i], d: 1'b0});
`ifdef PARITY_STOP_BIT_EN
        q.push_back('{b: p, d: 1'b0});
        q.push_back('{b: 1'b1, d: 1'b1});
`else
        q.push_back('{b: p, d: 1'b1});
`endif
    endtask

    // Called just after a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [7:0] b, input logic p);
        bus.data_in    = b;
        bus.data_valid = 1'b1;
        for (int i = 0; i < 40 && !bus.data_ready; i++) @(negedge clk);
        if (!bus.data_ready) begin
            chk("accept_timeout", 0, 1);
            bus.data_valid = 1'b0;
        end else begin
            @(posedge clk);
            push_frame(b, p);
            @(negedge clk);
            chk("parity_out", parity_out, p);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard monitor: every active serial cycle must match the next queued bit.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (ser_active) begin
                run++;
                if (q.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("ser_out", ser_out, e.b);
                    chk("frame_done", frame_done, e.d);
                end
            end else begin
                if (run != 0) last_run = run;
                run = 0;
                chk("gap_in_frame", q.size() != 0, 0);
                chk("idle_frame_done", frame_done, 0);
                chk("idle_ser_out", ser_out, 1);
            end
        end
    end

    logic [7:0] vec_d [4] = '{8'hBD, 8'h04, 8'h64, 8'hFF};
    logic       vec_p [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n           = 1'b0;
        bus.data_in     = '0;
        bus.data_valid  = 1'b0;
        bus_o.data_in   = '0;
        bus_o.data_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_data_ready", bus.data_ready, 1);
        chk("rst_ser_out", ser_out, 1);
        chk("rst_ser_active", ser_active, 0);
        chk("rst_parity_out", parity_out, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_odd_parity_out", so_par, 0);
        mon_en = 1'b1;
        @(negedge clk);

        // separate frames
        for (int v = 0; v < 4; v++) begin
            send(vec_d[v], vec_p[v]);
            bus.data_valid = 1'b0;
            drain();
            chk("single_run_len", last_run, FRAME_LEN);
        end

        // back-to-back frames with data_valid held
        send(8'h04, 1'b1);
        send(8'h64, 1'b1);
        bus.data_valid = 1'b0;
        drain();
        chk("b2b_run_len", last_run, 2 * FRAME_LEN);

        // reset in the middle of data bit 4
        send(8'hBD, 1'b0);
        bus.data_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("abort_data_ready", bus.data_ready, 1);
        chk("abort_ser_active", ser_active, 0);
        chk("abort_frame_done", frame_done, 0);
        chk("abort_ser_out", ser_out, 1);
        chk("abort_parity_out", parity_out, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_run_len", last_run, 5);

        // odd parity instance
        bus_o.data_in    = 8'hFF;
        bus_o.data_valid = 1'b1;
        chk("odd_ready", bus_o.data_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus_o.data_valid = 1'b0;
        chk("odd_parity_out", so_par, 1);
        for (int i = 0; i < FRAME_LEN; i++) begin
            chk("odd_ser_active", so_active, 1);
            chk("odd_ser_out", so_ser, 1);
            chk("odd_frame_done", so_done, (i == FRAME_LEN - 1) ? 1 : 0);
            @(negedge clk);
        end
        chk("odd_end_active", so_active, 0);
        chk("odd_end_done", so_done, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
